// File: rtl/gen_sync_pkg.sv
// gen_sync_pkg: shared constants for the multi-channel synchroniser
package gen_sync_pkg;
  localparam int GEN_SYNC_CNT_W = 8;
  localparam int GEN_SYNC_STAGES_MIN = 2;
  localparam int GEN_SYNC_STAGES_MAX = 4;
endpackage

// File: rtl/gen_sync_filt.sv
// gen_sync_filt: single-channel glitch filter and edge detector
// Ports: clk, rst (sync, active-high), s (synchronised level),
// level (filtered level), rise/fall (one-cycle pulses), upd (level accepts s this cycle).
// GEN_SYNC_FILTER_EN selects the FILT_CNT stability filter; otherwise level follows s.
module gen_sync_filt
  import gen_sync_pkg::*;
#(
  parameter int   FILT_CNT = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic level,
  output logic rise,
  output logic fall,
  output logic upd
);
  if (FILT_CNT < 1 || FILT_CNT > (1 << GEN_SYNC_CNT_W) - 1) begin : g_bad_filt
    $error("gen_sync_filt: FILT_CNT out of range");
  end
`ifdef GEN_SYNC_FILTER_EN
  localparam logic [GEN_SYNC_CNT_W-1:0] LAST = GEN_SYNC_CNT_W'(FILT_CNT - 1);
  logic [GEN_SYNC_CNT_W-1:0] cnt;
  assign upd = (s != level) && (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RST_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise  <= upd & s;
      fall  <= upd & ~s;
      level <= upd ? s : level;
      cnt   <= (s == level || upd) ? '0 : cnt + 1'b1;
    end
  end
`else
  assign upd = s != level;
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= s;
      rise  <= upd & s;
      fall  <= upd & ~s;
    end
  end
`endif
endmodule

// File: rtl/gen_sync_multi.sv
// gen_sync_multi: parametrised multi-channel level synchroniser with optional glitch filter
// Ports: clk, rst (sync, active-high), async_in[WIDTH] asynchronous levels,
// sync_out[WIDTH] filtered levels, rise_pulse/fall_pulse[WIDTH] one-cycle edges,
// chg_any (any pulse this cycle). Filter is compiled in with GEN_SYNC_FILTER_EN.
module gen_sync_multi
  import gen_sync_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}},
  parameter int               FILT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             chg_any
);
  if (STAGES < GEN_SYNC_STAGES_MIN || STAGES > GEN_SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gen_sync_multi: STAGES out of range");
  end
  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] upd;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RST_VAL;
      chg_any <= 1'b0;
    end else begin
      chain[0] <= async_in;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
      chg_any <= |upd;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    gen_sync_filt #(
      .FILT_CNT(FILT_CNT),
      .RST_VAL (RST_VAL[i])
    ) u_filt (
      .clk  (clk),
      .rst  (rst),
      .s    (chain[STAGES-1][i]),
      .level(sync_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i]),
      .upd  (upd[i])
    );
  end
endmodule

// File: tb/tb_gen_sync_multi.sv
// tb_gen_sync_multi: randomized check of gen_sync_multi against a history-window model
module tb_gen_sync_multi;
  localparam int W = 4;
  localparam int ST = 3;
  localparam int FC = 4;
  localparam logic [W-1:0] RV = 4'h0;
`ifdef GEN_SYNC_FILTER_EN
  localparam int EFF = FC;
`else
  localparam int EFF = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] sync_out, rise_pulse, fall_pulse;
  logic chg_any;
  gen_sync_multi #(.WIDTH(W), .STAGES(ST), .RST_VAL(RV), .FILT_CNT(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .sync_out  (sync_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .chg_any   (chg_any)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [W-1:0] hist [0:8191];
  int e = 0;
  logic [W-1:0] m_out = RV, m_rise = '0, m_fall = '0;
  logic m_chg = 1'b0;
  function automatic logic [W-1:0] s_at(input int k);
    return (k - ST >= 1) ? hist[k-ST] : RV;
  endfunction
  task automatic step(input logic [W-1:0] a, input logic r);
    logic [W-1:0] acc;
    async_in = a;
    rst = r;
    @(posedge clk);
    if (r) begin
      e = 0;
      m_out = RV;
      m_rise = '0;
      m_fall = '0;
      m_chg = 1'b0;
    end else begin
      e++;
      hist[e] = a;
      acc = '1;
      for (int j = 0; j < EFF; j++) acc &= s_at(e - j) ^ m_out;
      m_out = m_out ^ acc;
      m_rise = acc & m_out;
      m_fall = acc & ~m_out;
      m_chg = |acc;
    end
    #1;
    check("sync_out", 32'(sync_out), 32'(m_out));
    check("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    check("chg_any", 32'(chg_any), 32'(m_chg));
  endtask
  initial begin
    logic [W-1:0] a;
    repeat (2) step(4'hF, 1'b1);
    repeat (10) step(4'hF, 1'b0);
    step(4'h0, 1'b1);
    repeat (10) step(4'h0, 1'b0);
    repeat (3) step(4'h1, 1'b0);
    repeat (10) step(4'h0, 1'b0);
    repeat (4) step(4'h2, 1'b0);
    repeat (10) step(4'h0, 1'b0);
    repeat (10) step(4'h8, 1'b0);
    repeat (10) step(4'h4, 1'b0);
    repeat (ST + 2) step(4'h2, 1'b0);
    step(4'h2, 1'b1);
    repeat (10) step(4'h2, 1'b0);
    a = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(3) == 0) a[b] = ~a[b];
      step(a, $urandom_range(99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
